// File: rtl/sig_gen_sequencer.sv
// Step sequencer that plays a small table of waveform settings into the signal generator.
// Each entry carries sel/frequency/amplitude/duty plus a dwell time in prescaled ticks.
module sig_gen_sequencer #(
    parameter int unsigned STEPS    = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned DWELL_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [34+DWELL_W-1:0] cfg_data,
    input  logic [AW-1:0]         last_step,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  stop,
    output logic                  gen_on,
    output logic [1:0]            gen_sel,
    output logic [15:0]           gen_frequency,
    output logic [7:0]            gen_amplitude,
    output logic [7:0]            gen_duty_cycle,
    output logic [AW-1:0]         step_idx,
    output logic                  step_strobe,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = 34 + DWELL_W;
    localparam int unsigned PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       step_idx_q, step_idx_d;
    logic                gen_on_q, gen_on_d;
    logic [1:0]          gen_sel_q, gen_sel_d;
    logic [15:0]         gen_frequency_q, gen_frequency_d;
    logic [7:0]          gen_amplitude_q, gen_amplitude_d;
    logic [7:0]          gen_duty_cycle_q, gen_duty_cycle_d;
    logic                step_strobe_q, step_strobe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [PW-1:0]       presc_q, presc_d;

    logic [CW-1:0]       table_q [STEPS];

    logic [CW-1:0]       entry;
    logic [1:0]          entry_sel;
    logic [15:0]         entry_frequency;
    logic [7:0]          entry_amplitude;
    logic [7:0]          entry_duty_cycle;
    logic [DWELL_W-1:0]  entry_dwell;
    logic                tick_wrap;
    logic                step_end;
    logic                final_step;

    // Table has no reset; contents survive rst so a run can be replayed.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    // Combinational read sees the pre-write value when a write lands on the fetch edge.
    assign entry            = table_q[step_idx_q];
    assign entry_sel        = entry[CW-1 -: 2];
    assign entry_frequency  = entry[CW-3 -: 16];
    assign entry_amplitude  = entry[CW-19 -: 8];
    assign entry_duty_cycle = entry[CW-27 -: 8];
    assign entry_dwell      = entry[DWELL_W-1:0];

    assign tick_wrap  = (presc_q == PW'(TICK_DIV - 1));
    assign step_end   = tick_wrap && (dwell_q == DWELL_W'(1));
    // Running off the top of the table counts as the end of the sequence.
    assign final_step = (step_idx_q == last_step) || (step_idx_q == AW'(STEPS - 1));

    always_comb begin
        state_d          = state_q;
        step_idx_d       = step_idx_q;
        gen_on_d         = gen_on_q;
        gen_sel_d        = gen_sel_q;
        gen_frequency_d  = gen_frequency_q;
        gen_amplitude_d  = gen_amplitude_q;
        gen_duty_cycle_d = gen_duty_cycle_q;
        step_strobe_d    = 1'b0;
        done_d           = 1'b0;
        dwell_d          = dwell_q;
        presc_d          = presc_q;

        unique case (state_q)
            StIdle: begin
                gen_on_d = 1'b0;
                if (start && !stop) begin
                    step_idx_d = '0;
                    state_d    = StFetch;
                end
            end

            StFetch: begin
                if (stop) begin
                    gen_on_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    gen_on_d         = 1'b1;
                    gen_sel_d        = entry_sel;
                    gen_frequency_d  = entry_frequency;
                    gen_amplitude_d  = entry_amplitude;
                    gen_duty_cycle_d = entry_duty_cycle;
                    dwell_d          = (entry_dwell == '0) ? DWELL_W'(1) : entry_dwell;
                    presc_d          = '0;
                    step_strobe_d    = 1'b1;
                    state_d          = StRun;
                end
            end

            StRun: begin
                if (stop) begin
                    gen_on_d = 1'b0;
                    state_d  = StIdle;
                end else if (tick_wrap) begin
                    presc_d = '0;
                    dwell_d = dwell_q - DWELL_W'(1);
                    if (step_end) begin
                        if (!final_step) begin
                            step_idx_d = step_idx_q + AW'(1);
                            state_d    = StFetch;
                        end else if (loop_en) begin
                            step_idx_d = '0;
                            state_d    = StFetch;
                        end else begin
                            gen_on_d = 1'b0;
                            done_d   = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            default: begin
                gen_on_d = 1'b0;
                state_d  = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            step_idx_q       <= '0;
            gen_on_q         <= 1'b0;
            gen_sel_q        <= '0;
            gen_frequency_q  <= '0;
            gen_amplitude_q  <= '0;
            gen_duty_cycle_q <= '0;
            step_strobe_q    <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            dwell_q          <= '0;
            presc_q          <= '0;
        end else begin
            state_q          <= state_d;
            step_idx_q       <= step_idx_d;
            gen_on_q         <= gen_on_d;
            gen_sel_q        <= gen_sel_d;
            gen_frequency_q  <= gen_frequency_d;
            gen_amplitude_q  <= gen_amplitude_d;
            gen_duty_cycle_q <= gen_duty_cycle_d;
            step_strobe_q    <= step_strobe_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            dwell_q          <= dwell_d;
            presc_q          <= presc_d;
        end
    end

    assign gen_on         = gen_on_q;
    assign gen_sel        = gen_sel_q;
    assign gen_frequency  = gen_frequency_q;
    assign gen_amplitude  = gen_amplitude_q;
    assign gen_duty_cycle = gen_duty_cycle_q;
    assign step_idx       = step_idx_q;
    assign step_strobe    = step_strobe_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sig_gen_sequencer.sv
// Bench for sig_gen_sequencer: directed scenarios plus randomized tables checked against
// a step-schedule model built from per-step durations.
module tb_sig_gen_sequencer;

    localparam int STEPS = 8;
    localparam int AW    = 3;
    localparam int TICK  = 4;
    localparam int DW    = 16;
    localparam int CW    = 34 + DW;
    localparam int NMAX  = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_data = '0;
    logic [AW-1:0] last_step = '0;
    logic          loop_en = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          gen_on;
    logic [1:0]    gen_sel;
    logic [15:0]   gen_frequency;
    logic [7:0]    gen_amplitude;
    logic [7:0]    gen_duty_cycle;
    logic [AW-1:0] step_idx;
    logic          step_strobe;
    logic          busy;
    logic          done;

    sig_gen_sequencer #(
        .STEPS    (STEPS),
        .AW       (AW),
        .TICK_DIV (TICK),
        .DWELL_W  (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .last_step      (last_step),
        .loop_en        (loop_en),
        .start          (start),
        .stop           (stop),
        .gen_on         (gen_on),
        .gen_sel        (gen_sel),
        .gen_frequency  (gen_frequency),
        .gen_amplitude  (gen_amplitude),
        .gen_duty_cycle (gen_duty_cycle),
        .step_idx       (step_idx),
        .step_strobe    (step_strobe),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [CW-1:0] mdl_tab [STEPS];

    // Observed trace; index c is sampled 1 time unit after edge c, edge 0 samples start.
    logic          o_on [NMAX], o_strobe [NMAX], o_busy [NMAX], o_done [NMAX];
    logic [1:0]    o_sel [NMAX];
    logic [15:0]   o_freq [NMAX];
    logic [7:0]    o_amp [NMAX], o_duty [NMAX];
    logic [AW-1:0] o_idx [NMAX];

    logic          e_on [NMAX], e_strobe [NMAX], e_busy [NMAX], e_done [NMAX], e_gv [NMAX];
    logic [1:0]    e_sel [NMAX];
    logic [15:0]   e_freq [NMAX];
    logic [7:0]    e_amp [NMAX], e_duty [NMAX];
    logic [AW-1:0] e_idx [NMAX];

    int            act_c = -1;
    int            act_kind = 0;
    logic [AW-1:0] act_addr = '0;
    logic [CW-1:0] act_data = '0;

    function automatic logic [CW-1:0] mk(input logic [1:0] s, input logic [15:0] f,
                                         input logic [7:0] a, input logic [7:0] d,
                                         input logic [DW-1:0] w);
        return {s, f, a, d, w};
    endfunction

    task automatic write_entry(input int a, input logic [CW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a[AW-1:0];
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        mdl_tab[a] = d;
    endtask

    task automatic idle_out();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Pulse start, then record n samples; the optional action is driven after sample act_c.
    task automatic capture(input int n);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            start  = 1'b0;
            stop   = 1'b0;
            cfg_we = 1'b0;
            rst    = 1'b0;
            o_on[c] = gen_on;     o_sel[c] = gen_sel;     o_freq[c] = gen_frequency;
            o_amp[c] = gen_amplitude; o_duty[c] = gen_duty_cycle; o_idx[c] = step_idx;
            o_strobe[c] = step_strobe; o_busy[c] = busy;  o_done[c] = done;
            if (c == act_c) begin
                case (act_kind)
                    1: stop = 1'b1;
                    2: start = 1'b1;
                    3: begin cfg_we = 1'b1; cfg_addr = act_addr; cfg_data = act_data; end
                    4: begin rst = 1'b1; start = 1'b1; end
                    default: ;
                endcase
            end
        end
        start = 1'b0; stop = 1'b0; cfg_we = 1'b0; rst = 1'b0;
        act_kind = 0;
        act_c = -1;
    endtask

    // Schedule model: step j begins (strobe) at s_j, lasts max(dwell,1)*TICK+1 samples; the
    // sample before each strobe already shows the next index; the final sample of the
    // last non-looping step shows done with gen_on/busy low.
    task automatic predict(input int n, input int wr_edge, input int wr_addr,
                           input logic [CW-1:0] wr_data);
        int s, i, nxt, len, d;
        logic [CW-1:0] e;
        bit fin;
        for (int c = 0; c < n; c++) begin
            e_on[c] = 0; e_strobe[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_gv[c] = 0;
            e_idx[c] = '0; e_sel[c] = '0; e_freq[c] = '0; e_amp[c] = '0; e_duty[c] = '0;
        end
        e_busy[0] = 1;
        s = 1; i = 0; fin = 0;
        while (!fin && s < n) begin
            e = (wr_edge >= 0 && s > wr_edge && i == wr_addr) ? wr_data : mdl_tab[i];
            d = int'(e[DW-1:0]);
            if (d == 0) d = 1;
            len = d * TICK + 1;
            if (i == int'(last_step) || i == STEPS - 1) nxt = loop_en ? 0 : -1;
            else nxt = i + 1;
            for (int c = s; c < s + len && c < n; c++) begin
                e_gv[c] = 1; e_sel[c] = e[CW-1 -: 2]; e_freq[c] = e[CW-3 -: 16];
                e_amp[c] = e[CW-19 -: 8]; e_duty[c] = e[CW-27 -: 8];
                e_strobe[c] = (c == s);
                if (c < s + len - 1) begin
                    e_on[c] = 1; e_busy[c] = 1; e_idx[c] = AW'(i);
                end else if (nxt < 0) begin
                    e_done[c] = 1; e_idx[c] = AW'(i);
                end else begin
                    e_on[c] = 1; e_busy[c] = 1; e_idx[c] = AW'(nxt);
                end
            end
            if (nxt < 0) begin
                fin = 1;
                for (int c = s + len; c < n; c++) begin
                    e_gv[c] = 1; e_sel[c] = e[CW-1 -: 2]; e_freq[c] = e[CW-3 -: 16];
                    e_amp[c] = e[CW-19 -: 8]; e_duty[c] = e[CW-27 -: 8]; e_idx[c] = AW'(i);
                end
            end else begin
                s += len;
                i = nxt;
            end
        end
    endtask

    task automatic test_reset();
        logic [40:0] v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        v = {gen_on, gen_sel, gen_frequency, gen_amplitude, gen_duty_cycle, step_idx,
             step_strobe, busy, done};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", v);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int ons, dones;
        write_entry(0, mk(2'd0, 16'd1000, 8'd50, 8'd25, 16'd3));
        last_step = 3'd0;
        loop_en   = 1'b0;
        capture(20);
        n_cmp++;
        if ({o_on[1], o_sel[1], o_freq[1], o_strobe[1]} !== {1'b1, 2'd0, 16'd1000, 1'b1}) begin
            n_bad++;
            $display("FAIL single_first_step: got on=%b sel=%0d f=%0d stb=%b expected 1 0 1000 1",
                     o_on[1], o_sel[1], o_freq[1], o_strobe[1]);
        end
        ons = 0; dones = 0;
        for (int c = 0; c < 20; c++) begin
            ons += int'(o_on[c]);
            dones += int'(o_done[c]);
        end
        n_cmp++;
        if (ons != 12) begin
            n_bad++;
            $display("FAIL single_on_cycles: got %0d expected 12", ons);
        end
        n_cmp++;
        if ({o_done[13], o_on[13], o_busy[13], o_busy[12]} !== 4'b1001 || dones != 1) begin
            n_bad++;
            $display("FAIL single_end: got done=%b on=%b busy=%b prev_busy=%b count=%0d expected 1 0 0 1 1",
                     o_done[13], o_on[13], o_busy[13], o_busy[12], dones);
        end
        idle_out();
    endtask

    task automatic load_three();
        write_entry(0, mk(2'd0, 16'd100, 8'd10, 8'd10, 16'd1));
        write_entry(1, mk(2'd1, 16'd200, 8'd20, 8'd20, 16'd2));
        write_entry(2, mk(2'd2, 16'd300, 8'd30, 8'd30, 16'd1));
        last_step = 3'd2;
    endtask

    task automatic test_loop();
        int stb[$];
        int gaps[3] = '{5, 9, 5};
        int drops, dones;
        load_three();
        loop_en = 1'b1;
        capture(60);
        drops = 0; dones = 0;
        for (int c = 0; c < 60; c++) begin
            if (o_strobe[c]) stb.push_back(c);
            if (c >= 1 && !o_on[c]) drops++;
            dones += int'(o_done[c]);
        end
        n_cmp++;
        if (stb.size() < 6) begin
            n_bad++;
            $display("FAIL loop_strobe_count: got %0d expected >=6", stb.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (stb[k+1] - stb[k] != gaps[k]) begin
                    n_bad++;
                    $display("FAIL loop_gap%0d: got %0d expected %0d", k, stb[k+1] - stb[k], gaps[k]);
                end
            end
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (o_idx[stb[k]] !== AW'(k % 3) || o_sel[stb[k]] !== 2'(k % 3)) begin
                    n_bad++;
                    $display("FAIL loop_idx%0d: got idx=%0d sel=%0d expected %0d", k,
                             o_idx[stb[k]], o_sel[stb[k]], k % 3);
                end
            end
        end
        n_cmp++;
        if (drops != 0 || dones != 0) begin
            n_bad++;
            $display("FAIL loop_continuous: got drops=%0d dones=%0d expected 0 0", drops, dones);
        end
        idle_out();
    endtask

    task automatic test_stop();
        int dones;
        loop_en  = 1'b1;
        act_kind = 1;
        act_c    = 11;
        capture(20);
        dones = 0;
        for (int c = 0; c < 20; c++) dones += int'(o_done[c]);
        n_cmp++;
        if ({o_on[11], o_busy[11], o_on[12], o_busy[12], o_idx[12]} !== {4'b1100, 3'd1} ||
            dones != 0) begin
            n_bad++;
            $display("FAIL stop_abort: got on=%b%b busy=%b%b idx=%0d dones=%0d expected 10 10 1 0",
                     o_on[11], o_on[12], o_busy[11], o_busy[12], o_idx[12], dones);
        end
        capture(8);
        n_cmp++;
        if ({o_idx[0], o_idx[1], o_strobe[1], o_sel[1], o_freq[1]} !==
            {3'd0, 3'd0, 1'b1, 2'd0, 16'd100}) begin
            n_bad++;
            $display("FAIL stop_restart: got idx=%0d,%0d stb=%b sel=%0d f=%0d expected 0,0 1 0 100",
                     o_idx[0], o_idx[1], o_strobe[1], o_sel[1], o_freq[1]);
        end
        idle_out();
    endtask

    task automatic test_dwell0();
        int nstb, dones;
        write_entry(0, mk(2'd3, 16'd555, 8'd1, 8'd2, 16'd0));
        write_entry(1, mk(2'd1, 16'd777, 8'd3, 8'd4, 16'd1));
        last_step = 3'd1;
        loop_en   = 1'b0;
        act_kind  = 2;
        act_c     = 3;
        capture(16);
        nstb = 0; dones = 0;
        for (int c = 0; c < 16; c++) begin
            nstb += int'(o_strobe[c]);
            dones += int'(o_done[c]);
        end
        n_cmp++;
        if ({o_strobe[1], o_strobe[6], o_idx[6], o_freq[6]} !== {2'b11, 3'd1, 16'd777} ||
            nstb != 2) begin
            n_bad++;
            $display("FAIL dwell0_timing: got stb=%b%b idx=%0d f=%0d n=%0d expected 11 1 777 2",
                     o_strobe[1], o_strobe[6], o_idx[6], o_freq[6], nstb);
        end
        n_cmp++;
        if (o_done[10] !== 1'b1 || dones != 1) begin
            n_bad++;
            $display("FAIL dwell0_done: got done10=%b count=%0d expected 1 1", o_done[10], dones);
        end
        idle_out();
    endtask

    task automatic test_collision();
        logic [CW-1:0] nd;
        load_three();
        loop_en  = 1'b1;
        nd       = mk(2'd1, 16'd4096, 8'd20, 8'd20, 16'd2);
        act_kind = 3;
        act_c    = 5;
        act_addr = 3'd1;
        act_data = nd;
        capture(40);
        n_cmp++;
        if ({o_strobe[6], o_freq[6]} !== {1'b1, 16'd200}) begin
            n_bad++;
            $display("FAIL collision_old: got stb=%b f=%0d expected 1 200", o_strobe[6], o_freq[6]);
        end
        n_cmp++;
        if ({o_strobe[25], o_idx[25], o_freq[25]} !== {1'b1, 3'd1, 16'd4096}) begin
            n_bad++;
            $display("FAIL collision_new: got stb=%b idx=%0d f=%0d expected 1 1 4096",
                     o_strobe[25], o_idx[25], o_freq[25]);
        end
        mdl_tab[1] = nd;
        idle_out();
    endtask

    task automatic test_rst_midrun();
        logic [40:0] v;
        loop_en  = 1'b0;
        act_kind = 4;
        act_c    = 8;
        capture(12);
        v = {o_on[9], o_sel[9], o_freq[9], o_amp[9], o_duty[9], o_idx[9], o_strobe[9],
             o_busy[9], o_done[9]};
        n_cmp++;
        if (v !== '0 || o_busy[8] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_midrun: got %h busy_before=%b expected 0 1", v, o_busy[8]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, gen_on} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_idle: got busy=%b on=%b expected 0 0", busy, gen_on);
        end
        predict(24, -1, 0, '0);
        capture(24);
        for (int c = 1; c < 24; c++) begin
            n_cmp++;
            if ({o_on[c], o_strobe[c], o_done[c], o_freq[c]} !==
                {e_on[c], e_strobe[c], e_done[c], e_freq[c]}) begin
                n_bad++;
                $display("FAIL rst_replay@%0d: got on=%b stb=%b done=%b f=%0d expected %b %b %b %0d",
                         c, o_on[c], o_strobe[c], o_done[c], o_freq[c],
                         e_on[c], e_strobe[c], e_done[c], e_freq[c]);
            end
        end
        idle_out();
    endtask

    task automatic test_random();
        int n;
        n = 150;
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < STEPS; a++) begin
                write_entry(a, mk(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom),
                                  8'($urandom), 16'($urandom_range(0, 3))));
            end
            last_step = 3'($urandom_range(0, STEPS - 1));
            loop_en   = 1'($urandom_range(0, 1));
            predict(n, -1, 0, '0);
            capture(n);
            for (int c = 0; c < n; c++) begin
                n_cmp++;
                if ({o_on[c], o_strobe[c], o_busy[c], o_done[c], o_idx[c]} !==
                    {e_on[c], e_strobe[c], e_busy[c], e_done[c], e_idx[c]}) begin
                    n_bad++;
                    $display("FAIL rand%0d_ctrl@%0d: got on/stb/busy/done/idx=%b%b%b%b/%0d expected %b%b%b%b/%0d",
                             r, c, o_on[c], o_strobe[c], o_busy[c], o_done[c], o_idx[c],
                             e_on[c], e_strobe[c], e_busy[c], e_done[c], e_idx[c]);
                end
                if (e_gv[c]) begin
                    n_cmp++;
                    if ({o_sel[c], o_freq[c], o_amp[c], o_duty[c]} !==
                        {e_sel[c], e_freq[c], e_amp[c], e_duty[c]}) begin
                        n_bad++;
                        $display("FAIL rand%0d_gen@%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                                 r, c, o_sel[c], o_freq[c], o_amp[c], o_duty[c],
                                 e_sel[c], e_freq[c], e_amp[c], e_duty[c]);
                    end
                end
            end
            idle_out();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loop();
        test_stop();
        test_dwell0();
        test_collision();
        test_rst_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
